sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//  SHA-256 message-schedule expander. Accepts one 512-bit padded block and streams
//  schedule words W[0..NUM_WORDS-1] one per accepted beat to the compression rounds.
//  It is the consumer of the fixed-rotate helpers: sigma0 and sigma1 are built from them.
//  It sits between block padding/load and the round datapath.
// PARAMETERS
//  NUM_WORDS   64   number of schedule words emitted per block; legal range 16..64
// PORTS
//  clk          in   1    rising-edge clock
//  reset        in   1    asynchronous, active-high reset
//  blk_valid    in   1    blk_data holds a block to load
//  blk_ready    out  1    block can be accepted (high only in IDLE)
//  blk_data     in   512  block; word 0 = blk_data[511:480], word 15 = blk_data[31:0]
//  w_valid      out  1    w_data/w_index valid
//  w_ready      in   1    downstream accepts the word
//  w_data       out  32   schedule word W[w_index]
//  w_index      out  6    index t of current word, 0..NUM_WORDS-1
//  done         out  1    one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset is asynchronous and active-high.
//  Reset: state=IDLE, window cleared to 0, w_valid=0, w_index=0, w_data=0, done=0.
//   blk_ready=1 once reset deasserts.
//  Window: 16 x 32-bit registers win[0..15] hold W[t..t+15]; w_data = win[0].
//  Functions, all mod 2^32:
//   sig0(x) = ROTR7 ^ ROTR18 ^ SHR3
//   sig1(x) = ROTR17 ^ ROTR19 ^ SHR10
//   next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0]  (= W[t+16])
//   Sum is 32-bit, wrap-around, carries discarded.
//  FSM IDLE:
//   blk_ready=1, w_valid=0.
//   blk_valid&blk_ready: load win[i]=word i, w_index=0, go RUN.
//   First word valid the next cycle (1-cycle load latency).
//  FSM RUN:
//   blk_ready=0, w_valid=1.
//   Beat = w_valid&w_ready. On a beat: win shifts down by one, win[15]=next, w_index++.
//   No beat: win, w_index, w_data held stable (AXI-style; valid never drops without a beat).
//   Beat with w_index==NUM_WORDS-1: go IDLE, done=1 for exactly the next cycle,
//    w_valid=0 in that cycle.
//   The window keeps shifting with don't-care values once t+16 >= NUM_WORDS.
//   Those values never reach w_data.
//  blk_valid is ignored while in RUN; a new block can load in the cycle done is high.
//   That cycle is in IDLE, so blk_ready=1.
//  w_ready may be held high permanently: one word per cycle, NUM_WORDS cycles per block.
//  Reset asserted mid-RUN: immediate return to reset values; no done pulse; partial
//   stream abandoned.
//  All outputs are registered; no combinational path from w_ready/blk_valid to outputs
//   except through state.
// TESTING
//  1 "abc" block:
//    blk_data = 0x61626380, 14 x 0, 0x00000018, w_ready=1.
//    Required: W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000,
//    W63=0x12B1EDEB, done 1 cycle after W63.
//  2 Backpressure: same block, w_ready toggled pseudo-randomly.
//    Required: identical word sequence; w_data/w_index stable while w_ready=0.
//  3 Back-to-back: blk_valid held high with two blocks.
//    Required: second block loads in the done cycle; 64+64 words, no gap beyond the
//    load cycle.
//  4 Reset mid-stream: assert reset at w_index=30.
//    Required: w_valid=0 and blk_ready=1 immediately, no done; a fresh block restarts
//    at W0.
//  5 Wrap: all-ones block (16 x 0xFFFFFFFF).
//    Required: W16 = sig1(~0)+~0+sig0(~0)+~0 mod 2^32, checked against a reference
//    model; whole stream compared to the software model.
//  6 NUM_WORDS=16 build: exactly 16 words equal to input words; done after W15.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads one 512-bit block and streams
// W[0..NUM_WORDS-1] over a valid/ready handshake using a 16-word sliding window.
module sha256_msg_schedule #(
    parameter int NUM_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_index,
    output logic         done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    state_t      state_r;
    logic [31:0] win_r [16];
    logic [31:0] next_s;
    logic        beat_s;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    // Next schedule word W[t+16] from the current window, and the handshake beat.
    always_comb begin
        next_s = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];
        beat_s = w_valid & w_ready;
    end

    assign w_data = win_r[0];

    // Control FSM and window: load in IDLE, shift one word per beat in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'h0000_0000;
            end
            w_valid   <= 1'b0;
            w_index   <= 6'd0;
            blk_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            win_r[i] <= blk_data[511 - 32*i -: 32];
                        end
                        w_index   <= 6'd0;
                        w_valid   <= 1'b1;
                        blk_ready <= 1'b0;
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat_s) begin
                        // Tail words beyond NUM_WORDS are don't-care and never reach w_data.
                        for (int i = 0; i < 15; i++) begin
                            win_r[i] <= win_r[i + 1];
                        end
                        win_r[15] <= next_s;
                        if (w_index == LAST_IDX) begin
                            w_index   <= 6'd0;
                            w_valid   <= 1'b0;
                            blk_ready <= 1'b1;
                            done      <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            w_index <= 6'(w_index + 6'd1);
                        end
                    end
                end
                default: begin
                    w_valid   <= 1'b0;
                    blk_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" block, backpressure, back-to-back,
// mid-stream reset, all-ones wrap and a 16-word build, checked against a software model.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid, blk_ready;
    logic [511:0] blk_data;
    logic         w_valid, w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         done;

    logic         b16_valid, b16_ready;
    logic         w16_valid, w16_ready;
    logic [31:0]  w16_data;
    logic [5:0]   w16_index;
    logic         d16;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] exp_w [64];
    logic [31:0] exp_b [64];
    logic [31:0] got   [64];

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ONES = {512{1'b1}};

    always #5 clk = ~clk;

    sha256_msg_schedule #(.NUM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_index(w_index), .done(done)
    );

    sha256_msg_schedule #(.NUM_WORDS(16)) dut16 (
        .clk(clk), .reset(reset), .blk_valid(b16_valid), .blk_ready(b16_ready),
        .blk_data(blk_data), .w_valid(w16_valid), .w_ready(w16_ready), .w_data(w16_data),
        .w_index(w16_index), .done(d16)
    );

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic model(input logic [511:0] b);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) exp_w[i] = b[511 - 32*i -: 32];
            else        exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Load one block and consume the full 64-word stream against exp_w.
    task automatic run_block(input logic [511:0] b, input bit bp, input string tag);
        int  t;
        int  cyc;
        bit  rdy;
        check({tag, "_ready_idle"}, 32'(blk_ready), 32'd1);
        blk_data  = b;
        blk_valid = 1'b1;
        w_ready   = 1'b0;
        @(negedge clk);
        blk_valid = 1'b0;
        t = 0;
        cyc = 0;
        while (t < 64 && cyc < 2000) begin
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready = rdy;
            check($sformatf("%s_valid_%0d", tag, t), 32'(w_valid), 32'd1);
            check($sformatf("%s_ready_low_%0d", tag, t), 32'(blk_ready), 32'd0);
            check($sformatf("%s_index_%0d", tag, t), 32'(w_index), 32'(t));
            check($sformatf("%s_data_%0d", tag, t), w_data, exp_w[t]);
            got[t] = w_data;
            @(negedge clk);
            cyc++;
            if (rdy) t++;
        end
        check({tag, "_word_count"}, 32'(t), 32'd64);
        w_ready = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_valid_after"}, 32'(w_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(blk_ready), 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [511:0] blk16;

        reset = 1'b1;
        blk_valid = 1'b0;
        blk_data = '0;
        w_ready = 1'b0;
        b16_valid = 1'b0;
        w16_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_index", 32'(w_index), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
        check("rst_w_valid_idle", 32'(w_valid), 32'd0);

        // 1: "abc" block at full rate, plus hand-computed words.
        model(ABC);
        run_block(ABC, 1'b0, "abc");
        check("abc_W0", got[0], 32'h61626380);
        check("abc_W15", got[15], 32'h00000018);
        check("abc_W16", got[16], 32'h61626380);
        check("abc_W17", got[17], 32'h000F0000);
        check("abc_W63", got[63], 32'h12B1EDEB);

        // 2: same block with random backpressure.
        run_block(ABC, 1'b1, "bp");
        check("bp_W63", got[63], 32'h12B1EDEB);

        // 3: back-to-back blocks with blk_valid held high.
        model(ONES);
        for (int i = 0; i < 64; i++) exp_b[i] = exp_w[i];
        model(ABC);
        blk_data  = ABC;
        blk_valid = 1'b1;
        w_ready   = 1'b1;
        @(negedge clk);
        blk_data = ONES;
        for (int t = 0; t < 64; t++) begin
            check($sformatf("b2b_a_valid_%0d", t), 32'(w_valid), 32'd1);
            check($sformatf("b2b_a_index_%0d", t), 32'(w_index), 32'(t));
            check($sformatf("b2b_a_data_%0d", t), w_data, exp_w[t]);
            @(negedge clk);
        end
        check("b2b_done_a", 32'(done), 32'd1);
        check("b2b_gap_valid", 32'(w_valid), 32'd0);
        check("b2b_gap_ready", 32'(blk_ready), 32'd1);
        @(negedge clk);
        blk_valid = 1'b0;
        for (int t = 0; t < 64; t++) begin
            check($sformatf("b2b_b_valid_%0d", t), 32'(w_valid), 32'd1);
            check($sformatf("b2b_b_index_%0d", t), 32'(w_index), 32'(t));
            check($sformatf("b2b_b_data_%0d", t), w_data, exp_b[t]);
            @(negedge clk);
        end
        check("b2b_done_b", 32'(done), 32'd1);
        w_ready = 1'b0;
        @(negedge clk);

        // 4: reset at w_index 30, then a fresh block restarts at W0.
        blk_data  = ABC;
        blk_valid = 1'b1;
        w_ready   = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        cyc = 0;
        while (w_index != 6'd30 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_index30", 32'(w_index), 32'd30);
        check("mid_data30", w_data, exp_w[30]);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(w_valid), 32'd0);
        check("mid_rst_ready", 32'(blk_ready), 32'd1);
        check("mid_rst_index", 32'(w_index), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        w_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_no_done_%0d", k), 32'(done), 32'd0);
            check($sformatf("mid_idle_valid_%0d", k), 32'(w_valid), 32'd0);
            @(negedge clk);
        end
        run_block(ABC, 1'b0, "restart");

        // 5: all-ones block exercising modular wrap.
        model(ONES);
        run_block(ONES, 1'b0, "ones");
        check("ones_W16_hand", got[16], 32'h203FFFFC);

        // 6: 16-word build emits the input words unchanged.
        for (int i = 0; i < 16; i++) blk16[511 - 32*i -: 32] = (32'h01020304 * 32'(i + 1)) ^ 32'hA5A5A5A5;
        blk_data  = blk16;
        b16_valid = 1'b1;
        @(negedge clk);
        b16_valid = 1'b0;
        w16_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            check($sformatf("n16_valid_%0d", t), 32'(w16_valid), 32'd1);
            check($sformatf("n16_index_%0d", t), 32'(w16_index), 32'(t));
            check($sformatf("n16_data_%0d", t), w16_data, (32'h01020304 * 32'(t + 1)) ^ 32'hA5A5A5A5);
            @(negedge clk);
        end
        check("n16_done", 32'(d16), 32'd1);
        check("n16_valid_after", 32'(w16_valid), 32'd0);
        check("n16_ready_after", 32'(b16_ready), 32'd1);
        w16_ready = 1'b0;
        @(negedge clk);
        check("n16_done_one_cycle", 32'(d16), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
